// File: rtl/dec_3_if.sv
// Valid/ready bundle for dec_3: vector/weight/bias input side and result output side.
// The slave modport is the decoder. The master modport is the neighbouring stage or the bench.
interface dec_3_if #(
   parameter int BITSIZE = 16,
   parameter int N       = 6
);
   logic                   in_valid;
   logic                   in_ready;
   logic [BITSIZE*N-1:0]   x;
   logic [BITSIZE*N-1:0]   w;
   logic [BITSIZE-1:0]     b;
   logic                   out_valid;
   logic                   out_ready;
   logic [BITSIZE-1:0]     y;
   logic                   busy;

   modport slave (
      input  in_valid, x, w, b, out_ready,
      output in_ready, out_valid, y, busy
   );

   modport master (
      output in_valid, x, w, b, out_ready,
      input  in_ready, out_valid, y, busy
   );
endinterface

// File: rtl/dec_3.sv
// dec_3: y = sum(x[i]*w[i]) + b using one shared signed MAC over N cycles, with valid/ready on both ends.
// Optional macro DEC_3_SAT_EN clamps the final result to the BITSIZE signed range instead of wrapping.
module dec_3 #(
   parameter int BITSIZE = 16,
   parameter int FRAC    = 8,
   parameter int N       = 6
) (
   input  logic   clk,
   input  logic   reset,
   dec_3_if.slave bus
);
   localparam int ACC_W  = 2*BITSIZE + 3;
   localparam int PROD_W = 2*BITSIZE;
   localparam int RES_W  = ACC_W - FRAC;
   localparam int IDX_W  = $clog2(N);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N-1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                    r_state;
   state_t                    w_state_next;
   logic signed [BITSIZE-1:0] r_x [N];
   logic signed [BITSIZE-1:0] r_w [N];
   logic signed [BITSIZE-1:0] r_b;
   logic signed [ACC_W-1:0]   r_acc;
   logic [IDX_W-1:0]          r_idx;
   logic [BITSIZE-1:0]        r_y;
   logic                      r_out_valid;
   logic                      r_in_ready;
   logic                      r_busy;

   logic signed [PROD_W-1:0]  w_prod;
   logic signed [ACC_W-1:0]   w_prod_ext;
   logic signed [ACC_W-1:0]   w_acc_sum;
   logic signed [ACC_W-1:0]   w_bias_acc;
   logic signed [RES_W-1:0]   w_res;
   logic [BITSIZE-1:0]        w_y_final;
   logic                      w_last;

   // Clamp to the signed BITSIZE range: in range when all bits above the result sign agree with it.
   function automatic logic [BITSIZE-1:0] sat_res(input logic [RES_W-1:0] v);
      logic [BITSIZE-1:0] res;
      if (v[RES_W-1:BITSIZE-1] == {(RES_W-BITSIZE+1){v[RES_W-1]}}) begin
         res = v[BITSIZE-1:0];
      end else if (v[RES_W-1]) begin
         res = {1'b1, {(BITSIZE-1){1'b0}}};
      end else begin
         res = {1'b0, {(BITSIZE-1){1'b1}}};
      end
      return res;
   endfunction

   function automatic logic [BITSIZE-1:0] wrap_res(input logic [RES_W-1:0] v);
      return v[BITSIZE-1:0];
   endfunction

   assign w_prod     = r_x[r_idx] * r_w[r_idx];
   assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
   assign w_acc_sum  = r_acc + w_prod_ext;
   assign w_bias_acc = {{(ACC_W-BITSIZE-FRAC){bus.b[BITSIZE-1]}}, bus.b, {FRAC{1'b0}}};
   // The slice equals an arithmetic shift right by FRAC, so rounding is toward -inf.
   assign w_res      = w_acc_sum[ACC_W-1:FRAC];
   assign w_last     = (r_idx == LAST_IDX);

`ifdef DEC_3_SAT_EN
   assign w_y_final = sat_res(w_res);
`else
   assign w_y_final = wrap_res(w_res);
`endif

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state decode
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (bus.in_valid) begin
               w_state_next = MAC;
            end else begin
               w_state_next = IDLE;
            end
         end
         MAC: begin
            if (w_last) begin
               w_state_next = DONE;
            end else begin
               w_state_next = MAC;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               w_state_next = IDLE;
            end else begin
               w_state_next = DONE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Operand capture and accumulation datapath
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N; i++) begin
            r_x[i] <= {BITSIZE{1'b0}};
            r_w[i] <= {BITSIZE{1'b0}};
         end
         r_b   <= {BITSIZE{1'b0}};
         r_acc <= {ACC_W{1'b0}};
         r_idx <= {IDX_W{1'b0}};
         r_y   <= {BITSIZE{1'b0}};
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  for (int i = 0; i < N; i++) begin
                     r_x[i] <= bus.x[BITSIZE*i +: BITSIZE];
                     r_w[i] <= bus.w[BITSIZE*i +: BITSIZE];
                  end
                  r_b   <= bus.b;
                  r_acc <= w_bias_acc;
                  r_idx <= {IDX_W{1'b0}};
               end
            end
            MAC: begin
               r_acc <= w_acc_sum;
               r_idx <= r_idx + 1'b1;
               if (w_last) begin
                  r_y <= w_y_final;
               end
            end
            DONE: begin
               r_acc <= r_acc;
            end
            default: begin
               r_idx <= {IDX_W{1'b0}};
            end
         endcase
      end
   end

   // Handshake outputs registered from the upcoming state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_in_ready  <= (w_state_next == IDLE);
         r_out_valid <= (w_state_next == DONE);
         r_busy      <= (w_state_next != IDLE);
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.busy      = r_busy;
   assign bus.y         = r_y;
endmodule
